// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor helper and
// the 8N1 frame constants. Used by both the transmit and receive sides.
package uart_pkg;

    // 8N1 framing: one start bit, eight data bits, one stop bit.
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Transfer states. The serializer owns START_BIT/DATA_BITS/STOP_BIT,
    // the RAM-reading top owns IDLE/FETCH/DONE.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_START_BIT = 3'd2,
        S_DATA_BITS = 3'd3,
        S_STOP_BIT  = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Clock cycles per bit; integer division, the truncation error is the
    // only timing error since the baud counter reloads on every bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: accepts one byte over a valid/ready input and shifts it
// onto the line LSB first, framed by a start bit and a stop bit.
//
// Handshake: a byte moves on any sys_clk edge where i_byte_valid and
// o_byte_ready are both high. o_byte_ready is high only while the line is
// idle. The producer must hold i_byte stable while i_byte_valid is high.
// On the accepting edge the line is driven low (start bit begins).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    input  logic [7:0] i_byte,
    output logic       o_uart_txd,
    output logic       o_stop_last,
    output state_t     o_state
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 1) begin : g_bad_baud
        $error("uart_tx_serializer: CLKS_PER_BIT must be at least 1");
    end
    if (UART_STOP_BITS != 1) begin : g_bad_stop
        $error("uart_tx_serializer: only one stop bit is supported");
    end

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_txd;
    logic              w_bit_end;

    assign w_bit_end    = (r_baud_cnt == BAUD_LAST);
    assign o_byte_ready = (r_state == S_IDLE);
    // High during the final cycle of the stop bit; the line is free after
    // the next edge.
    assign o_stop_last  = (r_state == S_STOP_BIT) && w_bit_end;
    assign o_uart_txd   = r_txd;
    assign o_state      = r_state;

    // Frame sequencer: one baud counter reloaded at every bit boundary.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (i_byte_valid) begin
                        r_shift    <= i_byte;
                        r_txd      <= 1'b0;
                        r_baud_cnt <= '0;
                        r_state    <= S_START_BIT;
                    end
                end
                S_START_BIT: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_txd      <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_state    <= S_DATA_BITS;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA_BITS: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP_BIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP_BIT: begin
                    r_txd <= 1'b1;
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_from_ram.sv
// Reads NUM_BYTES bytes from a synchronous RAM starting at BASE_ADDR and
// sends them over the UART as 8N1. Start is a level request; done is a
// level held until start drops. Dropping start between bytes aborts the
// transfer, but a frame in flight always completes.
module uart_tx_from_ram
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int ADDR_W    = 15,
    parameter int BASE_ADDR = 0,
    parameter int NUM_BYTES = 32,
    parameter int RD_LAT    = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_rd_data,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_uart_txd,
    output logic              o_busy,
    output logic              o_done,
    output state_t            o_state
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);
    localparam longint LAST_ADDR = longint'(BASE_ADDR) + longint'(NUM_BYTES) - 64'sd1;
    localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

    if (NUM_BYTES < 1) begin : g_bad_num
        $error("uart_tx_from_ram: NUM_BYTES must be at least 1");
    end
    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
        $error("uart_tx_from_ram: RD_LAT must be 1 or 2");
    end
    if (BASE_ADDR < 0 || LAST_ADDR >= ADDR_SPAN) begin : g_bad_addr
        $error("uart_tx_from_ram: address range does not fit in ADDR_W");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_baud
        $error("uart_tx_from_ram: BAUD exceeds CLK_HZ");
    end

    // The top parks in S_START_BIT while the serializer owns the line;
    // o_state then reports the serializer's own phase.
    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [1:0]        r_lat_cnt;
    logic              r_busy;
    logic              r_done;

    logic   w_byte_valid;
    logic   w_byte_ready;
    logic   w_stop_last;
    state_t w_ser_state;

    // RAM data is valid RD_LAT cycles after the address settles; the
    // extra cycle accounts for the address being registered itself.
    assign w_byte_valid = (r_state == S_FETCH) && (r_lat_cnt == LAT_LAST);

    assign o_rd_addr = r_rd_addr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_state   = (r_state == S_START_BIT) ? w_ser_state : r_state;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .i_byte_valid (w_byte_valid),
        .o_byte_ready (w_byte_ready),
        .i_byte       (i_rd_data),
        .o_uart_txd   (o_uart_txd),
        .o_stop_last  (w_stop_last),
        .o_state      (w_ser_state)
    );

    // Transfer control: start accept, RAM fetch wait, byte sequencing, done.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_rd_addr  <= '0;
            r_byte_cnt <= '0;
            r_lat_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rd_addr  <= ADDR_W'(BASE_ADDR);
                        r_byte_cnt <= '0;
                        r_lat_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_byte_valid && w_byte_ready) begin
                        r_state <= S_START_BIT;
                    end else if (r_lat_cnt != LAT_LAST) begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                S_START_BIT: begin
                    if (w_stop_last) begin
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (!i_start) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_rd_addr  <= r_rd_addr + ADDR_W'(1);
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                            r_lat_cnt  <= '0;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    // A start still held high here never retriggers.
                    if (!i_start) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_from_ram.sv
// Bench for uart_tx_from_ram: two instances (RD_LAT=1 at address 0, and
// RD_LAT=2 at the top of the address space) against a cycle-level line
// model derived from the frame timing rules and a line decoder.
module tb_uart_tx_from_ram;
    import uart_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 10;
    localparam int ADDR_W = 15;
    localparam int LAT_A  = 1;
    localparam int BASE_A = 0;
    localparam int NB_A   = 4;
    localparam int LAT_B  = 2;
    localparam int BASE_B = 32'h7FFE;
    localparam int NB_B   = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start_r   [2];
    logic [7:0]        rd_data_w [2];
    logic [ADDR_W-1:0] rd_addr_w [2];
    logic              txd_w     [2];
    logic              busy_w    [2];
    logic              done_w    [2];
    state_t            state_w   [2];

    logic [7:0] mem_a [0:32767];
    logic [7:0] mem_b [0:32767];
    logic [7:0] ra1, rb1, rb2;

    int n_checks = 0;
    int n_fail   = 0;
    int mon_err  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        logic [31:0] data;
        int          drop_at;
        int          exp_frames;
        bit          exp_done;
        int          extra;
    } vec_t;
    vec_t vecs[6];

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- DUTs and RAM models ----------------
    uart_tx_from_ram #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE_A), .NUM_BYTES(NB_A), .RD_LAT(LAT_A)
    ) u_dut_a (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_start    (start_r[0]),
        .i_rd_data  (rd_data_w[0]),
        .o_rd_addr  (rd_addr_w[0]),
        .o_uart_txd (txd_w[0]),
        .o_busy     (busy_w[0]),
        .o_done     (done_w[0]),
        .o_state    (state_w[0])
    );

    uart_tx_from_ram #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE_B), .NUM_BYTES(NB_B), .RD_LAT(LAT_B)
    ) u_dut_b (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_start    (start_r[1]),
        .i_rd_data  (rd_data_w[1]),
        .o_rd_addr  (rd_addr_w[1]),
        .o_uart_txd (txd_w[1]),
        .o_busy     (busy_w[1]),
        .o_done     (done_w[1]),
        .o_state    (state_w[1])
    );

    // Synchronous RAMs with one and two cycles of read latency.
    always @(posedge sys_clk) begin
        ra1 <= mem_a[rd_addr_w[0]];
        rb1 <= mem_b[rd_addr_w[1]];
        rb2 <= rb1;
    end
    assign rd_data_w[0] = ra1;
    assign rd_data_w[1] = rb2;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line decoder: samples mid-bit after a falling edge, pushes bytes.
    task automatic line_mon(input int d);
        logic [7:0] b;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sys_rst_n === 1'b1 && txd_w[d] === 1'b0) begin
                repeat (CPB / 2) @(posedge sys_clk);
                #1;
                if (txd_w[d] !== 1'b0) mon_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge sys_clk);
                    #1;
                    b[i] = txd_w[d];
                end
                repeat (CPB) @(posedge sys_clk);
                #1;
                if (txd_w[d] !== 1'b1) mon_err++;
                got_q.push_back(b);
            end
        end
    endtask

    // ---------------- driver + model ----------------
    // Edge 0 is the first edge that samples start high. Byte k's start bit
    // begins at edge k*per + lat + 1 and lasts 10 bit times; the line is
    // high otherwise. rd_addr = base + (frames completed), capped.
    task automatic run_xfer(input int d, input int drop_at, input int nfr,
                            input bit exp_done, input int extra);
        int lat, nb, base, per, total, k, o, bi, kk;
        int wave_err, busy_err, done_err, addr_err, first_bad;
        logic exp_tx, exp_busy, exp_dn;
        logic [7:0] bytes [4];
        logic [ADDR_W-1:0] exp_addr;
        lat  = (d == 0) ? LAT_A : LAT_B;
        nb   = (d == 0) ? NB_A : NB_B;
        base = (d == 0) ? BASE_A : BASE_B;
        per  = 10 * CPB + lat + 1;
        total = nfr * per;
        for (int i = 0; i < 4; i++) bytes[i] = 8'h00;
        for (int i = 0; i < nb; i++) bytes[i] = (d == 0) ? mem_a[base + i] : mem_b[base + i];
        got_q.delete();
        exp_q.delete();
        mon_err = 0;
        for (int i = 0; i < nfr; i++) exp_q.push_back(bytes[i]);
        wave_err = 0; busy_err = 0; done_err = 0; addr_err = 0; first_bad = -1;

        @(negedge sys_clk);
        start_r[d] = 1'b1;
        for (int t = 0; t < total + extra; t++) begin
            @(posedge sys_clk);
            #1;
            if (t == drop_at) start_r[d] = 1'b0;
            k = t / per;
            o = t - k * per - (lat + 1);
            if (k < nfr && o >= 0) begin
                bi = o / CPB;
                if (bi == 0)      exp_tx = 1'b0;
                else if (bi <= 8) exp_tx = bytes[k][bi - 1];
                else              exp_tx = 1'b1;
            end else begin
                exp_tx = 1'b1;
            end
            exp_busy = exp_done ? 1'b1 : (t < total);
            exp_dn   = exp_done && (t >= total);
            kk = (k < nfr - 1) ? k : nfr - 1;
            exp_addr = ADDR_W'(base + kk);
            if (txd_w[d] !== exp_tx) begin
                wave_err++;
                if (first_bad < 0) first_bad = t;
            end
            if (busy_w[d] !== exp_busy) busy_err++;
            if (done_w[d] !== exp_dn) done_err++;
            if (rd_addr_w[d] !== exp_addr) addr_err++;
        end
        check($sformatf("txd waveform dut%0d (first bad edge %0d)", d, first_bad), wave_err, 0);
        check($sformatf("busy timing dut%0d", d), busy_err, 0);
        check($sformatf("done timing dut%0d", d), done_err, 0);
        check($sformatf("rd_addr sequence dut%0d", d), addr_err, 0);
        if (exp_done) begin
            check($sformatf("state in DONE dut%0d", d), 32'(state_w[d]), 32'(S_DONE));
            start_r[d] = 1'b0;
            @(posedge sys_clk);
            #1;
            check($sformatf("done falls after start low dut%0d", d), done_w[d], 1'b0);
            check($sformatf("busy falls after start low dut%0d", d), busy_w[d], 1'b0);
        end else begin
            start_r[d] = 1'b0;
            check($sformatf("state idle after abort dut%0d", d), 32'(state_w[d]), 32'(S_IDLE));
        end
        check($sformatf("frame framing dut%0d", d), mon_err, 0);
        check($sformatf("decoded frame count dut%0d", d), got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check($sformatf("decoded byte dut%0d", d), got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int stable_err;
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        sys_rst_n  = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        fork
            line_mon(0);
            line_mon(1);
        join_none

        // Reset values and idle stability.
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset txd", txd_w[0], 1'b1);
        check("reset busy", busy_w[0], 1'b0);
        check("reset done", done_w[0], 1'b0);
        check("reset rd_addr b", rd_addr_w[1], '0);
        check("reset state", 32'(state_w[0]), 32'(S_IDLE));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        stable_err = 0;
        for (int t = 0; t < 1000; t++) begin
            @(posedge sys_clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (txd_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 ||
                    rd_addr_w[d] !== '0)
                    stable_err++;
            end
        end
        check("idle outputs stable 1000 cycles", stable_err, 0);

        // Table of transfers on the RD_LAT=1 instance. Entries 0 and 1 are
        // back to back with a one-cycle start low in between.
        vecs[0] = '{32'hFF00A355, -1, 4, 1'b1, 150};
        vecs[1] = '{32'hFF00A355, -1, 4, 1'b1, 20};
        vecs[2] = '{$urandom, -1, 4, 1'b1, 20};
        vecs[3] = '{$urandom, int'($urandom_range(12, 91)), 1, 1'b0, 30};
        vecs[4] = '{$urandom, -1, 4, 1'b1, 20};
        vecs[5] = '{$urandom, -1, 4, 1'b1, 20};
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) mem_a[i] = vecs[v].data[8*i +: 8];
            run_xfer(0, vecs[v].drop_at, vecs[v].exp_frames, vecs[v].exp_done, vecs[v].extra);
        end

        // Asynchronous reset in the middle of a data bit (line driven low).
        mem_b[BASE_B]     = 8'h00;
        mem_b[BASE_B + 1] = 8'h00;
        @(negedge sys_clk);
        start_r[1] = 1'b1;
        repeat (40) @(posedge sys_clk);
        #1;
        check("line low before mid-bit reset", txd_w[1], 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async reset txd", txd_w[1], 1'b1);
        check("async reset busy", busy_w[1], 1'b0);
        check("async reset rd_addr", rd_addr_w[1], '0);
        start_r[1] = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (150) @(posedge sys_clk);
        got_q.delete();
        mon_err = 0;

        // RD_LAT=2 at the top of the address space, restarting after reset.
        mem_b[BASE_B]     = 8'h3C;
        mem_b[BASE_B + 1] = 8'hC3;
        run_xfer(1, -1, NB_B, 1'b1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_from_ram.md
# uart_tx_from_ram

Transmit side of the board's UART link. On a level start request, reads a fixed-length block of bytes from a synchronous single-port RAM and serializes each byte onto `uart_txd` as 8N1, LSB first. Raises `done` when the last stop bit has finished. It is the counterpart of the UART-to-RAM receiver and is used by the top-level sequencer to return the 256-bit hash result (32 bytes) to the host.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, `sys_clk` frequency in Hz
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, 434 at defaults)
- `ADDR_W`, 15, RAM address width
- `BASE_ADDR`, 0, first RAM address read
- `NUM_BYTES`, 32, bytes per transfer, ≥1
- `RD_LAT`, 1, RAM read latency in cycles, 1 or 2

Ports:
- `sys_clk`  in  1  clock
- `sys_rst_n`  in  1  reset: asynchronous, active-low
- `start`  in  1  level request; held high by the sequencer until it sees `done`
- `rd_data`  in  8  RAM read data, valid `RD_LAT` cycles after `rd_addr`
- `rd_addr`  out  `ADDR_W`  RAM read address
- `uart_txd`  out  1  serial line, idle high
- `busy`  out  1  high from the accept of `start` until return to IDLE
- `done`  out  1  transfer complete; level, held until `start` is low

## Operation
- Reset values (applied asynchronously): `uart_txd`=1, `busy`=0, `done`=0, `rd_addr`=0, state IDLE, byte/bit/baud counters 0.
- States: IDLE, FETCH, START_BIT, DATA_BITS, STOP_BIT, DONE.
- IDLE, `start`=1: set `rd_addr`=`BASE_ADDR`, clear the byte counter, `busy`=1, go to FETCH.
- FETCH: wait `RD_LAT` cycles, then capture `rd_data` into the shift register. Drive `uart_txd`=0 on that same edge and go to START_BIT.
- START_BIT: hold for `CLKS_PER_BIT` cycles, then go to DATA_BITS.
- DATA_BITS: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles, then go to STOP_BIT.
- STOP_BIT: `uart_txd`=1 for `CLKS_PER_BIT` cycles. Then:
  - if byte counter = `NUM_BYTES`-1: go to DONE;
  - else if `start`=0: go to IDLE with `busy`=0 and `done`=0 (abort);
  - else: increment `rd_addr` and the byte counter, go to FETCH.
- DONE: `done`=1, `busy`=1. When `start`=0, clear `done` and `busy` and go to IDLE. `start` still high in DONE never retriggers a transfer.
- `start` falling mid-byte never truncates a frame: the current byte always completes, including its stop bit.
- Elaboration check: `BASE_ADDR + NUM_BYTES - 1 < 2**ADDR_W`. `rd_addr` never wraps.
- `rd_addr` is stable outside FETCH entry. No write port; RAM enable is owned by the top level.

## Timing
- Start sampled high in IDLE at edge 0 → FETCH at edge 1 → start bit begins at edge `1+RD_LAT`.
- Frame length: exactly `10*CLKS_PER_BIT` cycles.
- Inter-byte gap: `RD_LAT`+1 extra idle-high cycles (legal as extended stop time).
- Total cycles from edge 0 to `done`=1: `NUM_BYTES*(10*CLKS_PER_BIT + RD_LAT + 1)`.
- `done` falls the cycle after `start`=0 is sampled in DONE.
- Bit timing uses one baud counter reloaded at every bit boundary, so there is no cumulative drift beyond the integer-division error.

## Structure
- Shared package `uart_pkg`: the FSM state enum, the `clks_per_bit(CLK_HZ, BAUD)` function, and the 8N1 constants (data bits = 8, stop bits = 1). The UART receiver uses the same package.
- Sub-module `uart_tx_serializer`: a `byte_valid`/`byte_ready` input that drives `uart_txd`, covering START_BIT, DATA_BITS and STOP_BIT.
- The top of this block holds IDLE/FETCH/DONE, address sequencing and the byte counter.

## Test plan
Bench uses `CLK_HZ`=1_000_000, `BAUD`=100_000, so `CLKS_PER_BIT`=10.
- Reset, no start → `uart_txd`=1, `busy`=0, `done`=0, `rd_addr`=0; all unchanged for 1000 cycles.
- `NUM_BYTES`=4, RAM[0..3]=0x55,0xA3,0x00,0xFF, `start` held → line decodes 0x55,0xA3,0x00,0xFF with 10-cycle bits; `done`=1 at cycle 4*(100+2)=408 and stays high until `start` drops; it falls one cycle after.
- `start` dropped during byte 1 data bits → byte 1 completes with its stop bit; address 1 is never presented; `busy`→0 and `done` stays 0.
- `sys_rst_n` pulsed low mid data bit → `uart_txd`=1 immediately (asynchronous); the next `start` restarts from `BASE_ADDR`.
- `RD_LAT`=2, `BASE_ADDR`=0x7FFE, `NUM_BYTES`=2, RAM=0x3C,0xC3 → addresses 0x7FFE then 0x7FFF; bytes 0x3C,0xC3; start bit at edge 3.
- `start` held high after `done` → no second frame; `start` low for 1 cycle then high → identical second transfer.
